// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between the memory stage and the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic        resp_valid;
    logic [63:0] rdata;
    logic        mem_error;
    logic        stall;
    modport master (
        output req_valid, addr, write, wdata,
        input  req_ready, resp_valid, rdata, mem_error, stall
    );
    modport slave (
        input  req_valid, addr, write, wdata,
        output req_ready, resp_valid, rdata, mem_error, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte-addressed quad-word data memory with range checking.
module data_mem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, wdata_q, data_q, rdata_q;
    logic        write_q, err_q, req_ready_q, resp_valid_q, mem_error_q;
    logic [7:0]  mem [MEM_BYTES];
    logic        accept, enter_resp, in_range, wr_eff;
    logic [63:0] a_eff, wd_eff, rd_word;
    logic [64:0] end_addr;
    logic [AW-1:0] idx;
    // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs are used then.
    always_comb begin
        accept     = state_q == IDLE && bus.req_valid;
        state_d    = state_q == IDLE ? (accept ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
                   : state_q == BUSY ? (cnt_q == 4'd1 ? RESP : BUSY) : IDLE;
        cnt_d      = accept ? 4'(LATENCY - 1) : state_q == BUSY ? cnt_q - 4'd1 : 4'd0;
        enter_resp = state_d == RESP && state_q != RESP;
        a_eff      = state_q == IDLE ? bus.addr : addr_q;
        wd_eff     = state_q == IDLE ? bus.wdata : wdata_q;
        wr_eff     = state_q == IDLE ? bus.write : write_q;
        end_addr   = {1'b0, a_eff} + 65'd8;
        in_range   = end_addr <= 65'(MEM_BYTES);
        idx        = a_eff[AW-1:0];
        rd_word    = '0;
        for (int i = 0; i < 8; i++) rd_word[8*i +: 8] = mem[idx + AW'(i)];
    end
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && wr_eff && in_range)
            for (int i = 0; i < 8; i++) mem[idx + AW'(i)] <= wd_eff[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            mem_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= state_d == IDLE;
            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                write_q <= bus.write;
            end
            if (enter_resp) begin
                data_q <= (!wr_eff && in_range) ? rd_word : '0;
                err_q  <= !in_range;
            end
            resp_valid_q <= state_q == RESP;
            rdata_q      <= state_q == RESP ? data_q : '0;
            mem_error_q  <= state_q == RESP && err_q;
        end
    end
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_error  = mem_error_q;
    assign bus.stall      = bus.req_valid & ~resp_valid_q & ~rst;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table plus latency-1 throughput and mid-store reset sequences.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    data_mem_responder_if b2 ();
    data_mem_responder_if b1 ();
    data_mem_responder #(.MEM_BYTES(1024), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    data_mem_responder #(.MEM_BYTES(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt [14];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Holds req_valid until the response, scrambling addr/wdata/write after acceptance.
    task automatic access2(input logic [63:0] a, input logic w, input logic [63:0] d,
                           output logic [63:0] rd, output logic er, output int lat, output logic stall_ok);
        int t;
        t = 0;
        while (!b2.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 64'(b2.req_ready), 64'd1);
        b2.req_valid = 1'b1;
        b2.addr      = a;
        b2.write     = w;
        b2.wdata     = d;
        @(negedge clk);
        b2.addr  = ~a;
        b2.wdata = ~d;
        b2.write = ~w;
        lat      = 0;
        stall_ok = 1'b1;
        while (!b2.resp_valid && lat < 50) begin
            if (!b2.stall) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (b2.stall) stall_ok = 1'b0;
        rd = b2.rdata;
        er = b2.mem_error;
        b2.req_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        logic [63:0] rd;
        logic        er, sok;
        int          lat;
        b2.req_valid = 1'b0; b2.addr = '0; b2.write = 1'b0; b2.wdata = '0;
        b1.req_valid = 1'b0; b1.addr = '0; b1.write = 1'b0; b1.wdata = '0;
        vt[0]  = '{64'h10, 1'b1, 64'h1122334455667788, 64'h0, 1'b0};
        vt[1]  = '{64'h18, 1'b1, 64'hAABBCCDDEEFF0099, 64'h0, 1'b0};
        vt[2]  = '{64'h10, 1'b0, 64'h0, 64'h1122334455667788, 1'b0};
        vt[3]  = '{64'h11, 1'b0, 64'h0, 64'h9911223344556677, 1'b0};
        vt[4]  = '{64'h3F8, 1'b1, 64'h0102030405060708, 64'h0, 1'b0};
        vt[5]  = '{64'h3F9, 1'b1, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b1};
        vt[6]  = '{64'h3F8, 1'b0, 64'h0, 64'h0102030405060708, 1'b0};
        vt[7]  = '{64'hFFFFFFFFFFFFFFFC, 1'b0, 64'h0, 64'h0, 1'b1};
        vt[8]  = '{64'hFFFFFFFFFFFFFFFC, 1'b1, 64'h1, 64'h0, 1'b1};
        vt[9]  = '{64'h3FC, 1'b0, 64'h0, 64'h0, 1'b1};
        vt[10] = '{64'h28, 1'b1, 64'h0000000012345678, 64'h0, 1'b0};
        vt[11] = '{64'h20, 1'b1, 64'h8877665544332211, 64'h0, 1'b0};
        vt[12] = '{64'h24, 1'b0, 64'h0, 64'h1234567888776655, 1'b0};
        vt[13] = '{64'h17, 1'b0, 64'h0, 64'hBBCCDDEEFF009911, 1'b0};
        repeat (3) @(negedge clk);
        b2.req_valid = 1'b1;
        chk("rst_req_ready", 64'(b2.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(b2.resp_valid), 64'd0);
        chk("rst_rdata", b2.rdata, 64'd0);
        chk("rst_mem_error", 64'(b2.mem_error), 64'd0);
        chk("rst_stall", 64'(b2.stall), 64'd0);
        b2.req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready2", 64'(b2.req_ready), 64'd1);
        chk("post_rst_ready1", 64'(b1.req_ready), 64'd1);
        for (int i = 0; i < 14; i++) begin
            access2(vt[i].addr, vt[i].wr, vt[i].wdata, rd, er, lat, sok);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
            chk($sformatf("vec%0d_stall", i), 64'(sok), 64'd1);
        end
        // LATENCY=1: request held high, second request follows two edges after the first.
        b1.req_valid = 1'b1; b1.addr = 64'h40; b1.write = 1'b1; b1.wdata = 64'hCAFEF00D12345678;
        @(negedge clk);
        chk("l1_a_resp_early", 64'(b1.resp_valid), 64'd0);
        chk("l1_a_ready", 64'(b1.req_ready), 64'd0);
        b1.addr = 64'h40; b1.write = 1'b0; b1.wdata = 64'h5555555555555555;
        @(negedge clk);
        chk("l1_a_resp", 64'(b1.resp_valid), 64'd1);
        chk("l1_a_err", 64'(b1.mem_error), 64'd0);
        chk("l1_a_rdata", b1.rdata, 64'd0);
        chk("l1_a_stall", 64'(b1.stall), 64'd0);
        @(negedge clk);
        chk("l1_b_resp_early", 64'(b1.resp_valid), 64'd0);
        chk("l1_b_ready", 64'(b1.req_ready), 64'd0);
        chk("l1_b_stall", 64'(b1.stall), 64'd1);
        b1.addr = 64'h3FF; b1.write = 1'b1; b1.wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        chk("l1_b_resp", 64'(b1.resp_valid), 64'd1);
        chk("l1_b_rdata", b1.rdata, 64'hCAFEF00D12345678);
        chk("l1_b_err", 64'(b1.mem_error), 64'd0);
        b1.req_valid = 1'b0;
        @(negedge clk);
        chk("l1_idle_resp", 64'(b1.resp_valid), 64'd0);
        // Reset on the edge that would commit a store.
        access2(64'h80, 1'b1, 64'h0F0E0D0C0B0A0908, rd, er, lat, sok);
        chk("pre_rst_store_err", 64'(er), 64'd0);
        b2.req_valid = 1'b1; b2.addr = 64'h80; b2.write = 1'b1; b2.wdata = 64'h7777777777777777;
        @(negedge clk);
        b2.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp", 64'(b2.resp_valid), 64'd0);
        chk("mid_rst_ready", 64'(b2.req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_resp", 64'(b2.resp_valid), 64'd0);
        chk("after_rst_ready", 64'(b2.req_ready), 64'd1);
        @(negedge clk);
        chk("after_rst_resp2", 64'(b2.resp_valid), 64'd0);
        access2(64'h80, 1'b0, 64'h0, rd, er, lat, sok);
        chk("aborted_store_rdata", rd, 64'h0F0E0D0C0B0A0908);
        chk("aborted_store_err", 64'(er), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
